// File: rtl/axi_rd_bridge.sv
// axi_rd_bridge: read-side bridge from a core request port to AXI4 AR/R.
// Accepts one read request at a time, issues a single AR transaction with the
// latched address/len/size, pushes each R beat through a one-entry response
// buffer and presents it on a valid/ready response port.
//
// Ports:
//   i_clk, i_rst_n                  clock (rising edge), async active-low reset
//   i_req_*, o_req_ready            core request (addr, len = beats-1, size)
//   o_rsp_*, i_rsp_ready            response beats (data, last, err)
//   o_proto_err                     sticky flag: RLAST disagreed with beat count
//   o_ar*, i_arready                AXI4 read-address channel
//   i_r*, o_rready                  AXI4 read-data channel (RID is ignored)
module axi_rd_bridge #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 64,
   parameter logic [3:0]  AXI_ID = 4'd0
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_req_valid,
   output logic              o_req_ready,
   input  logic [ADDR_W-1:0] i_req_addr,
   input  logic [2:0]        i_req_len,
   input  logic [2:0]        i_req_size,
   output logic              o_rsp_valid,
   input  logic              i_rsp_ready,
   output logic [DATA_W-1:0] o_rsp_data,
   output logic              o_rsp_last,
   output logic              o_rsp_err,
   output logic              o_proto_err,
   output logic              o_arvalid,
   input  logic              i_arready,
   output logic [ADDR_W-1:0] o_araddr,
   output logic [3:0]        o_arid,
   output logic [7:0]        o_arlen,
   output logic [2:0]        o_arsize,
   output logic [1:0]        o_arburst,
   input  logic              i_rvalid,
   output logic              o_rready,
   input  logic [DATA_W-1:0] i_rdata,
   input  logic [1:0]        i_rresp,
   input  logic              i_rlast,
   input  logic [3:0]        i_rid
);

   typedef enum logic [1:0] {StIdle, StAr, StR, StDrain} state_e;

   state_e              state_q, state_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [2:0]          len_q, len_d;
   logic [2:0]          size_q, size_d;
   logic [2:0]          cnt_q, cnt_d;
   logic                buf_valid_q, buf_valid_d;
   logic [DATA_W-1:0]   buf_data_q, buf_data_d;
   logic                buf_last_q, buf_last_d;
   logic                buf_err_q, buf_err_d;
   logic                proto_err_q, proto_err_d;

   logic                r_fire;
   logic                rsp_fire;
   logic                cnt_at_len;

   // RID is deliberately not checked.
   logic unused_rid;
   assign unused_rid = ^i_rid;

   // Accept a beat only when the buffer is empty or being drained this cycle.
   assign o_rready   = (state_q == StR) & (~buf_valid_q | i_rsp_ready);
   assign r_fire     = o_rready & i_rvalid;
   assign rsp_fire   = buf_valid_q & i_rsp_ready;
   assign cnt_at_len = (cnt_q == len_q);

   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      len_d       = len_q;
      size_d      = size_q;
      cnt_d       = cnt_q;
      buf_valid_d = buf_valid_q;
      buf_data_d  = buf_data_q;
      buf_last_d  = buf_last_q;
      buf_err_d   = buf_err_q;
      proto_err_d = proto_err_q;

      // A load wins over a drain, so a simultaneous consume+load keeps valid high.
      if (r_fire) begin
         buf_valid_d = 1'b1;
         buf_data_d  = i_rdata;
         buf_err_d   = (i_rresp != 2'b00);
         buf_last_d  = cnt_at_len;
      end else if (rsp_fire) begin
         buf_valid_d = 1'b0;
      end

      unique case (state_q)
         StIdle: begin
            if (i_req_valid) begin
               addr_d  = i_req_addr;
               len_d   = i_req_len;
               size_d  = i_req_size;
               cnt_d   = 3'd0;
               state_d = StAr;
            end
         end
         StAr: begin
            if (i_arready) state_d = StR;
         end
         StR: begin
            if (r_fire) begin
               cnt_d = cnt_q + 3'd1;
               // The beat counter decides where the burst ends; RLAST is only audited.
               if (i_rlast != cnt_at_len) proto_err_d = 1'b1;
               if (cnt_at_len) state_d = StDrain;
            end
         end
         StDrain: begin
            if (rsp_fire) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q     <= StIdle;
         addr_q      <= '0;
         len_q       <= '0;
         size_q      <= '0;
         cnt_q       <= '0;
         buf_valid_q <= 1'b0;
         buf_data_q  <= '0;
         buf_last_q  <= 1'b0;
         buf_err_q   <= 1'b0;
         proto_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         len_q       <= len_d;
         size_q      <= size_d;
         cnt_q       <= cnt_d;
         buf_valid_q <= buf_valid_d;
         buf_data_q  <= buf_data_d;
         buf_last_q  <= buf_last_d;
         buf_err_q   <= buf_err_d;
         proto_err_q <= proto_err_d;
      end
   end

   assign o_req_ready = (state_q == StIdle);
   assign o_arvalid   = (state_q == StAr);
   assign o_araddr    = addr_q;
   assign o_arid      = AXI_ID;
   assign o_arlen     = {5'b0, len_q};
   assign o_arsize    = size_q;
   // Burst type is only meaningful with arvalid; keep it low otherwise.
   assign o_arburst   = o_arvalid ? 2'b01 : 2'b00;
   assign o_rsp_valid = buf_valid_q;
   assign o_rsp_data  = buf_data_q;
   assign o_rsp_last  = buf_last_q;
   assign o_rsp_err   = buf_err_q;
   assign o_proto_err = proto_err_q;

endmodule

// File: tb/tb_axi_rd_bridge.sv
// Self-checking bench for axi_rd_bridge. The bench plays the core and an AXI
// slave; a queue of expected beats and a sticky expected protocol flag form
// the reference model.
module tb_axi_rd_bridge;

   localparam int unsigned ADDR_W = 32;
   localparam int unsigned DATA_W = 64;

   logic              i_clk;
   logic              i_rst_n;
   logic              i_req_valid;
   logic              o_req_ready;
   logic [ADDR_W-1:0] i_req_addr;
   logic [2:0]        i_req_len;
   logic [2:0]        i_req_size;
   logic              o_rsp_valid;
   logic              i_rsp_ready;
   logic [DATA_W-1:0] o_rsp_data;
   logic              o_rsp_last;
   logic              o_rsp_err;
   logic              o_proto_err;
   logic              o_arvalid;
   logic              i_arready;
   logic [ADDR_W-1:0] o_araddr;
   logic [3:0]        o_arid;
   logic [7:0]        o_arlen;
   logic [2:0]        o_arsize;
   logic [1:0]        o_arburst;
   logic              i_rvalid;
   logic              o_rready;
   logic [DATA_W-1:0] i_rdata;
   logic [1:0]        i_rresp;
   logic              i_rlast;
   logic [3:0]        i_rid;

   axi_rd_bridge #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W),
      .AXI_ID (4'd0)
   ) u_dut (
      .i_clk       (i_clk),
      .i_rst_n     (i_rst_n),
      .i_req_valid (i_req_valid),
      .o_req_ready (o_req_ready),
      .i_req_addr  (i_req_addr),
      .i_req_len   (i_req_len),
      .i_req_size  (i_req_size),
      .o_rsp_valid (o_rsp_valid),
      .i_rsp_ready (i_rsp_ready),
      .o_rsp_data  (o_rsp_data),
      .o_rsp_last  (o_rsp_last),
      .o_rsp_err   (o_rsp_err),
      .o_proto_err (o_proto_err),
      .o_arvalid   (o_arvalid),
      .i_arready   (i_arready),
      .o_araddr    (o_araddr),
      .o_arid      (o_arid),
      .o_arlen     (o_arlen),
      .o_arsize    (o_arsize),
      .o_arburst   (o_arburst),
      .i_rvalid    (i_rvalid),
      .o_rready    (o_rready),
      .i_rdata     (i_rdata),
      .i_rresp     (i_rresp),
      .i_rlast     (i_rlast),
      .i_rid       (i_rid)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   typedef struct packed {
      logic [63:0] data;
      logic        last;
      logic        err;
   } beat_t;

   int n_checks = 0;
   int n_errors = 0;
   bit proto_exp = 1'b0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic idle_inputs();
      i_req_valid = 1'b0;
      i_arready   = 1'b0;
      i_rvalid    = 1'b0;
      i_rsp_ready = 1'b0;
      i_rlast     = 1'b0;
      i_rresp     = 2'b00;
   endtask

   // One request/response transaction. rsp_mode: 0 always ready, 1 toggling
   // (1,0,1,0...), 2 random. err_mask/rlast_pat give per-beat RRESP error and
   // RLAST value. abort_at >= 0 stops once that many R beats were accepted.
   task automatic do_txn(input logic [31:0] addr, input logic [2:0] len, input logic [2:0] size,
                         input int ar_stall, input int rsp_mode, input bit rgap,
                         input logic [7:0] err_mask, input logic [7:0] rlast_pat,
                         input logic [63:0] data_base, input int abort_at, output int cycles);
      beat_t q[$];
      beat_t b;
      int    beats_sent = 0;
      int    ar_cnt = 0;
      int    tick;
      int    bi;
      bit    ar_done = 1'b0;
      bit    done = 1'b0;
      bit    aborted = 1'b0;
      logic  exp_rready;

      @(negedge i_clk);
      i_req_valid = 1'b1;
      i_req_addr  = addr;
      i_req_len   = len;
      i_req_size  = size;
      #1;
      check("req_ready_idle", o_req_ready, 1);
      @(posedge i_clk);

      for (tick = 0; tick < 300 && !done; tick++) begin
         @(negedge i_clk);
         i_req_valid = 1'b0;
         i_req_addr  = $urandom;  // scramble: AR fields must come from latched copies
         i_req_len   = 3'($urandom);
         i_req_size  = 3'($urandom);
         i_arready   = (ar_cnt >= ar_stall);
         bi          = beats_sent & 7;
         i_rvalid    = ar_done && (beats_sent <= int'(len)) && (!rgap || $urandom_range(0, 3) != 0);
         i_rdata     = data_base + 64'(beats_sent) * 64'h0101_0101_0101_0101;
         i_rresp     = err_mask[bi] ? 2'b10 : 2'b00;
         i_rlast     = rlast_pat[bi];
         i_rid       = 4'($urandom);
         case (rsp_mode)
            0:       i_rsp_ready = 1'b1;
            1:       i_rsp_ready = (tick % 2 == 0);
            default: i_rsp_ready = 1'($urandom_range(0, 1));
         endcase
         #1;
         check("proto_err", o_proto_err, proto_exp);
         check("req_ready_busy", o_req_ready, 0);
         if (tick == 0) check("arvalid_n1", o_arvalid, 1);
         if (!ar_done) begin
            check("arvalid", o_arvalid, 1);
            check("araddr", o_araddr, addr);
            check("arlen", o_arlen, {5'b0, len});
            check("arsize", o_arsize, size);
            check("arburst", o_arburst, 2'b01);
            check("arid", o_arid, 4'd0);
         end else begin
            check("arvalid_once", o_arvalid, 0);
         end
         exp_rready = ar_done && (beats_sent <= int'(len)) && (q.size() == 0 || i_rsp_ready);
         check("rready", o_rready, exp_rready);
         check("rsp_valid", o_rsp_valid, q.size() != 0);

         if (o_rsp_valid && i_rsp_ready) begin
            if (q.size() == 0) begin
               check("rsp_extra", 1, 0);
            end else begin
               b = q.pop_front();
               check("rsp_data", o_rsp_data, b.data);
               check("rsp_last", o_rsp_last, b.last);
               check("rsp_err", o_rsp_err, b.err);
            end
         end
         if (i_rvalid && o_rready) begin
            b.data = i_rdata;
            b.last = (beats_sent == int'(len));
            b.err  = err_mask[bi];
            q.push_back(b);
            if (i_rlast != b.last) proto_exp = 1'b1;
            beats_sent++;
         end
         if (!ar_done) begin
            if (o_arvalid && i_arready) ar_done = 1'b1;
            ar_cnt++;
         end
         done = ar_done && (beats_sent > int'(len)) && (q.size() == 0);
         if (abort_at >= 0 && beats_sent == abort_at) begin
            done    = 1'b1;
            aborted = 1'b1;
         end
         @(posedge i_clk);
      end
      if (!done) check("txn_timeout", 0, 1);
      cycles = tick;

      if (!aborted) begin
         @(negedge i_clk);
         idle_inputs();
         #1;
         check("req_ready_k1", o_req_ready, 1);
         check("proto_err_end", o_proto_err, proto_exp);
      end
   endtask

   task automatic pulse_reset();
      @(negedge i_clk);
      i_rst_n = 1'b0;
      idle_inputs();
      #1;
      check("rst_rsp_valid", o_rsp_valid, 0);
      check("rst_arvalid", o_arvalid, 0);
      check("rst_rready", o_rready, 0);
      check("rst_proto_err", o_proto_err, 0);
      proto_exp = 1'b0;
      @(negedge i_clk);
      i_rst_n = 1'b1;
      #1;
      check("rst_req_ready", o_req_ready, 1);
   endtask

   initial begin
      int          cyc;
      logic [2:0]  rl;
      logic [7:0]  pat;

      i_rst_n    = 1'b0;
      i_req_addr = '0;
      i_req_len  = '0;
      i_req_size = '0;
      i_rdata    = '0;
      i_rid      = '0;
      idle_inputs();
      #23;
      check("reset_req_ready", o_req_ready, 1);
      check("reset_arvalid", o_arvalid, 0);
      check("reset_rsp_valid", o_rsp_valid, 0);
      check("reset_rready", o_rready, 0);
      check("reset_proto_err", o_proto_err, 0);
      check("reset_rsp_data", o_rsp_data, 0);
      i_rst_n = 1'b1;

      // Single beat, minimum turnaround.
      do_txn(32'h8000_0000, 3'd0, 3'd3, 0, 0, 0, 8'h00, 8'h01, 64'h1122_3344_5566_7788, -1, cyc);
      check("turnaround", cyc, 3);
      // Four beats with toggling response backpressure.
      do_txn(32'h1000_0040, 3'd3, 3'd3, 0, 1, 0, 8'h00, 8'h08, 64'hA0A0_0000_0000_0001, -1, cyc);
      // AR stall for three cycles.
      do_txn(32'h2000_0100, 3'd1, 3'd2, 3, 0, 0, 8'h00, 8'h02, 64'h0BAD_F00D_0000_0000, -1, cyc);
      // Error response on beat 0 only.
      do_txn(32'h3000_0000, 3'd1, 3'd3, 0, 0, 0, 8'h01, 8'h02, 64'h5555_AAAA_0000_0010, -1, cyc);
      // Early RLAST on beat 1; the burst still runs to four beats.
      do_txn(32'h4000_0000, 3'd3, 3'd3, 0, 0, 0, 8'h00, 8'h0A, 64'hC0DE_0000_0000_0000, -1, cyc);
      check("proto_set", o_proto_err, 1);
      // Flag stays set across a clean transaction.
      do_txn(32'h4000_1000, 3'd0, 3'd3, 0, 0, 0, 8'h00, 8'h01, 64'h1234_5678_9ABC_DEF0, -1, cyc);
      pulse_reset();

      // Random clean traffic.
      for (int i = 0; i < 30; i++) begin
         rl  = 3'($urandom);
         pat = 8'h01 << rl;
         do_txn($urandom, rl, 3'($urandom_range(0, 3)), $urandom_range(0, 3), 2,
                1'($urandom_range(0, 1)), 8'($urandom), pat, {$urandom, $urandom}, -1, cyc);
      end

      // Missing RLAST on a single-beat transaction.
      do_txn(32'h5000_0000, 3'd0, 3'd3, 0, 0, 0, 8'h00, 8'h00, 64'hDEAD_BEEF_0000_0000, -1, cyc);
      check("proto_missing_rlast", o_proto_err, 1);

      // Reset in the middle of an 8-beat burst, then a clean single beat.
      do_txn(32'h6000_0000, 3'd7, 3'd3, 0, 0, 0, 8'h00, 8'h80, 64'h7777_0000_0000_0000, 2, cyc);
      pulse_reset();
      do_txn(32'h6000_1000, 3'd0, 3'd3, 0, 0, 0, 8'h00, 8'h01, 64'h0123_4567_89AB_CDEF, -1, cyc);

      // Random traffic with occasional bad RLAST patterns.
      for (int i = 0; i < 20; i++) begin
         rl  = 3'($urandom);
         pat = ($urandom_range(0, 4) == 0) ? 8'($urandom) : (8'h01 << rl);
         do_txn($urandom, rl, 3'($urandom_range(0, 3)), $urandom_range(0, 2), 2,
                1'($urandom_range(0, 1)), 8'($urandom), pat, {$urandom, $urandom}, -1, cyc);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
